fir_mac_seq: RTL and testbench
==============================

# fir_mac_seq

Sample-driven 64-tap FIR compute sequencer that sits directly downstream of the coefficient/sample memory block (`MEM_top`). For each accepted input sample it:

- writes the sample into the circular x history through the memory's `xload`/`xaddr`/`xin` port;
- sweeps all taps via `caddr`/`xaddr`;
- multiply-accumulates the returned `coeffCurr`/`xCurr` pairs;
- emits one rounded, saturated Q15 output per input.

## Interface

Parameters:

- `TAPS`, 64: tap count; equals memory depth.
- `AW`, 6: address width, log2(TAPS).
- `DW`, 16: sample/coefficient width, signed Q15.
- `ACCW`, 38: accumulator width, 2*DW + AW.

Ports:

- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `sample_valid` input 1: new input sample offered.
- `sample_in` input DW: signed input sample.
- `sample_ready` output 1: block can accept a sample this cycle.
- `xload` output 1: x-memory write enable to `MEM_top`.
- `xaddr` output AW: x-memory address, used for write and read.
- `xin` output DW: x-memory write data.
- `caddr` output AW: coefficient-memory read address.
- `xCurr` input DW: x read data, valid 1 cycle after `xaddr`.
- `coeffCurr` input DW: coefficient read data, valid 1 cycle after `caddr`.
- `y_valid` output 1: one-cycle pulse, new output available.
- `y_out` output DW: rounded, saturated Q15 result; held until next `y_valid`.
- `acc_out` output ACCW: full-precision accumulator result; held with `y_out`.
- `busy` output 1: high in every state except IDLE.

## Operation

- Block never drives `cload`. Coefficients are loaded by the host before the first sample; during operation they are treated as static.
- FSM states: CLEAR, IDLE, WRITE, READ, DRAIN, DONE.
- **CLEAR** (entered on reset): 64 cycles with `xload`=1, `xin`=0, `xaddr`=0..63; `sample_ready`=0. Exits to IDLE after address 63.
- **IDLE**: `sample_ready`=1. On `sample_valid`&&`sample_ready`, latch `sample_in`, then go to WRITE.
- **WRITE** (1 cycle): `xload`=1, `xaddr`=`head`, `xin`=latched sample. Accumulator cleared.
- **READ** (64 cycles, k=0..63): `xload`=0, `caddr`=k, `xaddr`=(`head`−k) mod 64. The k=0 read must return the sample written in WRITE.
- **DRAIN** (1 cycle): receives the k=63 data; no new address is issued.
- **MAC**: in each cycle after a read address (READ k≥1 and DRAIN), acc += sign-extended `coeffCurr` × `xCurr`. The product is 32-bit signed; the accumulator is ACCW signed with no overflow possible.
- **DONE** (1 cycle):
  - `acc_out` ← acc.
  - `y_out` ← sat16((acc + 2^14) >>> 15), clamped to [0x8000, 0x7FFF].
  - `y_valid`=1.
  - `head` ← `head`+1 mod 64 (wraps 63→0).
  - Then go to IDLE.
- `sample_valid` outside IDLE is ignored; no sample is queued.
- **Reset values**:
  - state=CLEAR; `head`=0; acc=0.
  - `y_out`=0, `acc_out`=0, `y_valid`=0, `sample_ready`=0, `busy`=1.
  - `xload`=0 in the reset cycle itself; `xaddr`=0, `caddr`=0, `xin`=0.
- **Reset mid-operation**: aborts immediately, no `y_valid`, `head` returns to 0, CLEAR reruns.

## Timing

- Accept edge at cycle T.
  - WRITE at T+1.
  - READ at T+2..T+65.
  - DRAIN at T+66.
  - DONE with `y_valid`=1 at T+67.
  - IDLE and `sample_ready`=1 at T+68.
- Throughput: one sample per 68 cycles.
- After `rst` deasserts, `sample_ready` rises 64 cycles later.
- `y_out`/`acc_out` change only in the DONE cycle.

## Test plan

- **Reset/clear**: release `rst` → `xload` high for 64 cycles with `xaddr` 0..63, `xin`=0; `sample_ready` rises on cycle 64; `y_out`=0.
- **Impulse response**: coeff[k]=k, input 0x7FFF then 70 zeros → i-th `y_out`=i for i=0..63; 65th output=0 (impulse left window, `head` wrapped).
- **DC/rounding**: all coeff 0x4000; input 0x2000 then zeros → `y_out`=0x1000 for 64 outputs, then 0x0000.
- **Saturation**: all coeff 0x7FFF; 64 samples of 0x7FFF → final `y_out`=0x7FFF and `acc_out`=64×0x3FFF0001. Then 64 samples of 0x8000 → final `y_out`=0x8000.
- **Handshake**: `sample_valid` held high continuously → accepts exactly every 68 cycles, `y_valid` 67 cycles after each accept. Pulses while `busy` produce no extra outputs.
- **Reset mid-READ**: assert `rst` at READ k=30 → no `y_valid`, CLEAR reruns, and the next impulse test matches the fresh-reset result.

Source files
------------

// File: rtl/fir_mac_seq.sv
// Sequencer for a 64-tap FIR filter. It writes each sample into the circular x history,
// sweeps every tap against the coefficient memory, then rounds and saturates the sum to Q15.
module fir_mac_seq #(
  parameter int TAPS = 64,
  parameter int AW   = 6,
  parameter int DW   = 16,
  parameter int ACCW = 38
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sample_valid,
  input  logic [DW-1:0]   sample_in,
  output logic            sample_ready,
  output logic            xload,
  output logic [AW-1:0]   xaddr,
  output logic [DW-1:0]   xin,
  output logic [AW-1:0]   caddr,
  input  logic [DW-1:0]   xCurr,
  input  logic [DW-1:0]   coeffCurr,
  output logic            y_valid,
  output logic [DW-1:0]   y_out,
  output logic [ACCW-1:0] acc_out,
  output logic            busy
);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [AW-1:0]          LAST_IDX   = AW'(TAPS - 1);
  localparam logic signed [ACCW-1:0] ROUND_HALF = {{(ACCW-DW+1){1'b0}}, 1'b1, {(DW-2){1'b0}}};

  state_t                  r_state;
  state_t                  w_nextState;
  logic [AW-1:0]           r_cnt;
  logic [AW-1:0]           r_head;
  logic [DW-1:0]           r_sample;
  logic signed [ACCW-1:0]  r_acc;
  logic [DW-1:0]           r_yOut;
  logic [ACCW-1:0]         r_accOut;

  logic                    w_lastCnt;
  logic                    w_macEn;
  logic signed [2*DW-1:0]  w_product;
  logic signed [ACCW-1:0]  w_productExt;
  logic signed [ACCW-1:0]  w_accNext;
  logic signed [ACCW-1:0]  w_rounded;
  logic signed [ACCW-1:0]  w_shifted;
  logic                    w_fits;
  logic [DW-1:0]           w_ySat;

  assign w_lastCnt = (r_cnt == LAST_IDX);

  // Read data lags the address by one cycle, so the MAC runs from READ k=1 through DRAIN.
  assign w_macEn      = ((r_state == S_READ) && (r_cnt != '0)) || (r_state == S_DRAIN);
  assign w_product    = $signed(coeffCurr) * $signed(xCurr);
  assign w_productExt = $signed({{(ACCW-2*DW){w_product[2*DW-1]}}, w_product});
  assign w_accNext    = r_acc + w_productExt;

  assign w_rounded = w_accNext + ROUND_HALF;
  assign w_shifted = w_rounded >>> (DW - 1);
  assign w_fits    = (w_shifted[ACCW-1:DW-1] == {(ACCW-DW+1){w_shifted[DW-1]}});
  assign w_ySat    = w_fits ? w_shifted[DW-1:0]
                            : {w_shifted[ACCW-1], {(DW-1){~w_shifted[ACCW-1]}}};

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_CLEAR: if (w_lastCnt)    w_nextState = S_IDLE;
      S_IDLE:  if (sample_valid) w_nextState = S_WRITE;
      S_WRITE:                   w_nextState = S_READ;
      S_READ:  if (w_lastCnt)    w_nextState = S_DRAIN;
      S_DRAIN:                   w_nextState = S_DONE;
      S_DONE:                    w_nextState = S_IDLE;
      default:                   w_nextState = S_CLEAR;
    endcase
  end

  // Strobes are gated by rst so nothing is written or handshaken while reset is held.
  always_comb begin
    sample_ready = 1'b0;
    xload        = 1'b0;
    xaddr        = '0;
    xin          = '0;
    caddr        = '0;
    y_valid      = 1'b0;
    busy         = rst || (r_state != S_IDLE);
    case (r_state)
      S_CLEAR: begin
        xload = !rst;
        xaddr = r_cnt;
      end
      S_IDLE: begin
        sample_ready = !rst;
      end
      S_WRITE: begin
        xload = !rst;
        xaddr = r_head;
        xin   = r_sample;
      end
      S_READ: begin
        xaddr = r_head - r_cnt;
        caddr = r_cnt;
      end
      S_DONE: begin
        y_valid = !rst;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_CLEAR;
      r_cnt    <= '0;
      r_head   <= '0;
      r_sample <= '0;
      r_acc    <= '0;
      r_yOut   <= '0;
      r_accOut <= '0;
    end else begin
      r_state <= w_nextState;

      if ((r_state == S_CLEAR) || (r_state == S_READ))
        r_cnt <= r_cnt + 1'b1;
      else
        r_cnt <= '0;

      if ((r_state == S_IDLE) && sample_valid)
        r_sample <= sample_in;

      if (r_state == S_WRITE)
        r_acc <= '0;
      else if (w_macEn)
        r_acc <= w_accNext;

      // Results are captured on the final MAC edge so they are already stable while y_valid is high.
      if (r_state == S_DRAIN) begin
        r_accOut <= w_accNext;
        r_yOut   <= w_ySat;
      end

      if (r_state == S_DONE)
        r_head <= r_head + 1'b1;
    end
  end

  assign y_out   = r_yOut;
  assign acc_out = r_accOut;

endmodule

// File: tb/tb_fir_mac_seq.sv
// Bench for fir_mac_seq: a stand-in for the coefficient/sample memory, a directed driver,
// and a monitor that pops hand-computed expectations from a scoreboard queue on each y_valid.
module tb_fir_mac_seq;

  localparam int TAPS = 64;
  localparam int AW   = 6;
  localparam int DW   = 16;
  localparam int ACCW = 38;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            sample_valid = 1'b0;
  logic [DW-1:0]   sample_in = '0;
  logic            sample_ready;
  logic            xload;
  logic [AW-1:0]   xaddr;
  logic [DW-1:0]   xin;
  logic [AW-1:0]   caddr;
  logic [DW-1:0]   xCurr = '0;
  logic [DW-1:0]   coeffCurr = '0;
  logic            y_valid;
  logic [DW-1:0]   y_out;
  logic [ACCW-1:0] acc_out;
  logic            busy;

  always #5 clk = ~clk;

  fir_mac_seq #(.TAPS(TAPS), .AW(AW), .DW(DW), .ACCW(ACCW)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .sample_ready (sample_ready),
    .xload        (xload),
    .xaddr        (xaddr),
    .xin          (xin),
    .caddr        (caddr),
    .xCurr        (xCurr),
    .coeffCurr    (coeffCurr),
    .y_valid      (y_valid),
    .y_out        (y_out),
    .acc_out      (acc_out),
    .busy         (busy)
  );

  // Memory model: one-cycle registered reads; x starts with junk that CLEAR must wipe.
  logic [DW-1:0] coeffMem [TAPS];
  logic [DW-1:0] xMem [TAPS] = '{default: 16'hA5A5};

  always @(posedge clk) begin
    if (xload) xMem[xaddr] <= xin;
    xCurr     <= xMem[xaddr];
    coeffCurr <= coeffMem[caddr];
  end

  int cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  typedef struct {
    logic [DW-1:0] y;
    longint        acc;
    int            acceptCyc;
  } exp_t;

  exp_t          expQ[$];
  exp_t          popped;
  int            nChecks    = 0;
  int            nFails     = 0;
  int            yCount     = 0;
  int            prevAccept = -1;
  logic          holdValid  = 1'b0;
  logic [DW-1:0] lastY      = '0;

  task automatic checkOutput(input string name, input longint act, input longint req);
    nChecks++;
    if (act !== req) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cycleCnt);
    end
  endtask

  function automatic logic [DW-1:0] satRound(input longint a);
    longint r;
    r = (a + 64'sd16384) >>> 15;
    if (r > 64'sd32767)  return 16'h7FFF;
    if (r < -64'sd32768) return 16'h8000;
    return r[DW-1:0];
  endfunction

  // Monitor: every y_valid must match the oldest expectation, 67 cycles after its accept.
  always @(negedge clk) begin
    if (rst) begin
      lastY = '0;
    end else if (y_valid) begin
      yCount++;
      if (expQ.size() == 0) begin
        checkOutput("yValidWithoutExpect", longint'(y_valid), 0);
      end else begin
        popped = expQ.pop_front();
        checkOutput("yOut", longint'(y_out), longint'(popped.y));
        checkOutput("accOut", longint'($signed(acc_out)), popped.acc);
        checkOutput("latency", longint'(cycleCnt - popped.acceptCyc), 67);
      end
      lastY = y_out;
    end else begin
      checkOutput("yHeld", longint'(y_out), longint'(lastY));
    end
  end

  task automatic applyStimulus(input logic [DW-1:0] s, input logic [DW-1:0] ey, input longint eacc);
    int waited = 0;
    @(negedge clk);
    while (!sample_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!sample_ready) begin
      checkOutput("readyTimeout", longint'(sample_ready), 1);
      return;
    end
    sample_in    = s;
    sample_valid = 1'b1;
    if (holdValid && prevAccept >= 0)
      checkOutput("acceptSpacing", longint'(cycleCnt - prevAccept), 68);
    prevAccept = cycleCnt;
    expQ.push_back('{y: ey, acc: eacc, acceptCyc: cycleCnt});
    @(posedge clk);
    #1;
    if (!holdValid) sample_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int waited = 0;
    while (expQ.size() != 0 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("drainQueueEmpty", longint'(expQ.size()), 0);
    @(posedge clk);
    #1;
  endtask

  // Caller must be positioned just after a rising edge.
  task automatic applyReset();
    rst          = 1'b1;
    sample_valid = 1'b0;
    expQ.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstXload", longint'(xload), 0);
    checkOutput("rstReady", longint'(sample_ready), 0);
    checkOutput("rstBusy", longint'(busy), 1);
    checkOutput("rstYValid", longint'(y_valid), 0);
    checkOutput("rstYOut", longint'(y_out), 0);
    checkOutput("rstAccOut", longint'(acc_out), 0);
    checkOutput("rstXaddr", longint'(xaddr), 0);
    checkOutput("rstCaddr", longint'(caddr), 0);
    checkOutput("rstXin", longint'(xin), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < TAPS; k++) begin
      @(negedge clk);
      checkOutput("clearXload", longint'(xload), 1);
      checkOutput("clearXaddr", longint'(xaddr), longint'(k));
      checkOutput("clearXin", longint'(xin), 0);
      checkOutput("clearReady", longint'(sample_ready), 0);
    end
    @(negedge clk);
    checkOutput("readyAfterClear", longint'(sample_ready), 1);
    checkOutput("yOutAfterClear", longint'(y_out), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic loadImpulseCoeffs();
    for (int k = 0; k < TAPS; k++) coeffMem[k] = DW'(k);
  endtask

  // Impulse through coeff[k]=k: output i is i (acc = 32767*i) until the impulse leaves the window.
  task automatic runImpulse();
    loadImpulseCoeffs();
    for (int i = 0; i <= 70; i++) begin
      if (i < 64) applyStimulus((i == 0) ? 16'h7FFF : 16'h0000, DW'(i), 64'sd32767 * i);
      else        applyStimulus(16'h0000, 16'h0000, 0);
    end
    waitDrain();
  endtask

  initial begin
    int snap;
    longint a;

    @(posedge clk);
    #1;
    applyReset();
    runImpulse();

    // DC/rounding: 0x4000 * 0x2000 = 2^27 gives 0x1000 for each of the 64 windowed outputs.
    applyReset();
    for (int k = 0; k < TAPS; k++) coeffMem[k] = 16'h4000;
    for (int i = 0; i <= 64; i++) begin
      if (i < 64) applyStimulus((i == 0) ? 16'h2000 : 16'h0000, 16'h1000, 64'sd134217728);
      else        applyStimulus(16'h0000, 16'h0000, 0);
    end
    waitDrain();

    // Saturation: 0x7FFF*0x7FFF = 0x3FFF0001 and 0x7FFF*0x8000 = -0x3FFF8000 per tap.
    applyReset();
    for (int k = 0; k < TAPS; k++) coeffMem[k] = 16'h7FFF;
    for (int n = 1; n <= 64; n++) begin
      a = 64'sd1073676289 * n;
      applyStimulus(16'h7FFF, satRound(a), a);
    end
    for (int m = 1; m <= 64; m++) begin
      a = 64'sd1073676289 * (64 - m) - 64'sd1073709056 * m;
      applyStimulus(16'h8000, satRound(a), a);
    end
    waitDrain();

    // Continuous valid: accepts every 68 cycles.
    applyReset();
    loadImpulseCoeffs();
    holdValid  = 1'b1;
    prevAccept = -1;
    applyStimulus(16'h7FFF, 16'd0, 0);
    applyStimulus(16'h0000, 16'd1, 64'sd32767);
    applyStimulus(16'h0000, 16'd2, 64'sd65534);
    applyStimulus(16'h0000, 16'd3, 64'sd98301);
    holdValid    = 1'b0;
    sample_valid = 1'b0;
    waitDrain();

    // Pulses while busy must be ignored; history is 7FFF,0,0,0 so a new 7FFF gives taps 0 and 4.
    snap = yCount;
    applyStimulus(16'h7FFF, 16'd4, 64'sd131068);
    for (int p = 0; p < 5; p++) begin
      repeat (9) @(posedge clk);
      #1;
      sample_in    = 16'h1234;
      sample_valid = 1'b1;
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
    end
    waitDrain();
    repeat (150) @(posedge clk);
    #1;
    checkOutput("busyPulseOutputs", longint'(yCount - snap), 1);

    // Reset during READ k=30 aborts the sample; a fresh impulse run must match.
    applyReset();
    loadImpulseCoeffs();
    applyStimulus(16'h7FFF, 16'd0, 0);
    for (int w = 0; w < 100 && cycleCnt != prevAccept + 32; w++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("midReadCaddr", longint'(caddr), 30);
    snap = yCount;
    applyReset();
    checkOutput("noYAfterAbort", longint'(yCount), longint'(snap));
    runImpulse();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion before 2000000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
